// File: rtl/char_disp_ctrl.sv
// Text-mode 800x600@60 display controller: timing counters plus a five-cycle
// fetch pipeline through a character RAM and font ROM toward the HDMI encoder.
module char_disp_ctrl #(
  parameter int          H_ACTIVE = 800,
  parameter int          H_FP     = 40,
  parameter int          H_SYNC   = 128,
  parameter int          H_BP     = 88,
  parameter int          V_ACTIVE = 600,
  parameter int          V_FP     = 1,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 23,
  parameter int          COLS     = 100,
  parameter int          ROWS     = 37,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic        hdmi_pll_LOCKED,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [23:0] rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_TXT  = 10'(ROWS * 16);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] COLS_W = 12'(COLS);

  // Per-pixel control carried alongside the memory fetches.
  typedef struct packed {
    logic [2:0] px;
    logic [3:0] ln;
    logic       act;
    logic       txt;
    logic       hs;
    logic       vs;
    logic       fs;
  } ctl_t;

  logic        flush;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  ctl_t        ctl0;
  logic [11:0] char_addr_d;
  ctl_t        ctl_q [1:4];
  logic [4:1]  vld_q;
  logic [11:0] char_addr_q;
  logic [11:0] font_addr_q, font_addr_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, de_q, fs_q;

  assign flush = rst | ~hdmi_pll_LOCKED;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (flush) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: decode the current counter position.
  always_comb begin
    ctl0.px  = h_cnt_q[2:0];
    ctl0.ln  = v_cnt_q[3:0];
    ctl0.act = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    ctl0.txt = ctl0.act && (v_cnt_q < V_TXT);
    ctl0.hs  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    ctl0.vs  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    ctl0.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    char_addr_d = '0;
    if (ctl0.txt)
      char_addr_d = {6'd0, v_cnt_q[9:4]} * COLS_W + {4'd0, h_cnt_q[10:3]};
  end

  // Font address uses the char code returned one cycle after char_addr.
  always_comb begin
    font_addr_d = '0;
    if (vld_q[2] && ctl_q[2].txt)
      font_addr_d = {char_data, ctl_q[2].ln};
  end

  always_comb begin
    rgb_d = '0;
    if (vld_q[4] && ctl_q[4].act)
      rgb_d = (ctl_q[4].txt && font_data[3'(~ctl_q[4].px)]) ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge hdmi_clk) begin
    if (flush) begin
      for (int i = 1; i <= 4; i++) ctl_q[i] <= '0;
      vld_q       <= '0;
      char_addr_q <= '0;
      font_addr_q <= '0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      ctl_q[1] <= ctl0;
      vld_q[1] <= 1'b1;
      for (int i = 2; i <= 4; i++) begin
        ctl_q[i] <= ctl_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
      char_addr_q <= char_addr_d;
      font_addr_q <= font_addr_d;
      rgb_q       <= rgb_d;
      hs_q        <= vld_q[4] & ctl_q[4].hs;
      vs_q        <= vld_q[4] & ctl_q[4].vs;
      de_q        <= vld_q[4] & ctl_q[4].act;
      fs_q        <= vld_q[4] & ctl_q[4].fs;
    end
  end

  assign char_addr   = char_addr_q;
  assign font_addr   = font_addr_q;
  assign rgb         = rgb_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_char_disp_ctrl.sv
// Bench for char_disp_ctrl: random char/font memories, every output compared each
// cycle against a pixel-position reference model (vertical timing shortened).
module tb_char_disp_ctrl;

  localparam int H_ACTIVE = 800, H_FP = 40, H_SYNC = 128, H_BP = 88;
  localparam int V_ACTIVE = 52, V_FP = 1, V_SYNC = 4, V_BP = 3;
  localparam int COLS = 100, ROWS = 3;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h102030;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, lock;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic [23:0] rgb;
  logic        hs, vs, de, frame_start;

  logic [7:0] cram  [0:4095];
  logic [7:0] fontm [0:4095];

  int checks = 0;
  int failures = 0;
  int n = 0;

  always #5 clk = ~clk;

  char_disp_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COLS(COLS), .ROWS(ROWS), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .hdmi_clk(clk), .rst(rst), .hdmi_pll_LOCKED(lock),
    .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data),
    .rgb(rgb), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    char_data <= cram[char_addr];
    font_data <= fontm[font_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  function automatic bit is_txt(input int p);
    int q = p % FRAME;
    return (q % HT < H_ACTIVE) && (q / HT < ROWS * 16);
  endfunction

  function automatic int exp_caddr(input int p);
    int q = p % FRAME;
    if (!is_txt(p)) return 0;
    return ((q / HT) / 16) * COLS + (q % HT) / 8;
  endfunction

  function automatic int exp_faddr(input int p);
    int q = p % FRAME;
    if (!is_txt(p)) return 0;
    return int'(cram[exp_caddr(p)]) * 16 + (q / HT) % 16;
  endfunction

  function automatic logic [23:0] exp_rgb(input int p);
    int q = p % FRAME;
    int h = q % HT;
    int v = q / HT;
    logic [7:0] bits;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 24'h0;
    if (v >= ROWS * 16) return BG;
    bits = fontm[exp_faddr(p)];
    return bits[7 - h % 8] ? FG : BG;
  endfunction

  function automatic logic [3:0] exp_sync(input int p);
    int q = p % FRAME;
    int h = q % HT;
    int v = q / HT;
    logic [3:0] r;
    r[3] = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    r[2] = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    r[1] = (h < H_ACTIVE) && (v < V_ACTIVE);
    r[0] = (q == 0);
    return r;
  endfunction

  // One clock: n counts enabled edges since the last flush, so the output
  // shows pixel n-5, char_addr pixel n-1 and font_addr pixel n-3.
  task automatic step();
    logic [51:0] obs, exp;
    @(posedge clk);
    if (rst || !lock) n = 0;
    else n++;
    @(negedge clk);
    exp = '0;
    if (n >= 5) begin
      exp[51:28] = exp_rgb(n - 5);
      exp[27:24] = exp_sync(n - 5);
    end
    if (n >= 1) exp[23:12] = 12'(exp_caddr(n - 1));
    if (n >= 3) exp[11:0]  = 12'(exp_faddr(n - 3));
    obs = {rgb, hs, vs, de, frame_start, char_addr, font_addr};
    check("pixel", 64'(obs), 64'(exp));
    if (n == 5) check("frame_start_first", 64'(frame_start), 64'd1);
    if (n - 1 == 33 * HT + 15) check("char_addr_15_33", 64'(char_addr), 64'd201);
    if (n - 3 == 33 * HT + 15) check("font_addr_15_33", 64'(font_addr), 64'h5A1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic expect_dark(input string tag);
    check(tag, 64'({rgb, hs, vs, de, frame_start}), 64'd0);
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      cram[i]  = 8'($urandom_range(0, 255));
      fontm[i] = 8'($urandom_range(0, 255));
    end
    cram[201] = 8'h5A;

    run(4);
    rst = 1'b0;
    run(6);
    expect_dark("locked_low");
    lock = 1'b1;
    run(FRAME + 20);
    $display("full frame plus wrap: checks=%0d failures=%0d", checks, failures);

    begin
      int guard = 0;
      while ((n % FRAME) != 2 * HT + 400 && guard < 5000) begin
        step();
        guard++;
      end
      check("reach_lockdrop_point", 64'(n % FRAME), 64'(2 * HT + 400));
    end
    lock = 1'b0;
    step();
    expect_dark("lock_drop_flush");
    run(2);
    lock = 1'b1;
    run(HT + 20);
    $display("lock drop and relock: checks=%0d failures=%0d", checks, failures);

    run(500);
    rst = 1'b1;
    step();
    expect_dark("rst_pulse_flush");
    rst = 1'b0;
    run(HT + 20);
    $display("reset pulse mid-line: checks=%0d failures=%0d", checks, failures);

    rst = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      cram[i]  = 8'h41;
      fontm[i] = 8'h81;
    end
    step();
    rst = 1'b0;
    run(2 * HT + 20);
    $display("fixed 0x41/0x81 pattern: checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_disp_ctrl.md
Name: char_disp_ctrl

Overview:
- Text-mode display controller for the Show_Char HDMI path. Generates 800x600@60 timing (40 MHz pixel clock) and sequences a pipelined fetch through an external character RAM and font ROM.
- Delivers timing-aligned RGB, HS, VS and DE to the hdmi_tx encoder.
- Gated by hdmi_pll_LOCKED, so no video reaches the encoder until the PLL is locked.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, HS pulse width
- H_BP, 88, horizontal back porch (H_TOTAL = 1056)
- V_ACTIVE, 600, active lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, VS pulse width
- V_BP, 23, vertical back porch (V_TOTAL = 628)
- COLS, 100, character columns (8 px wide)
- ROWS, 37, character rows (16 lines tall)
- FG_COLOR, 24'hFFFFFF, RGB when font bit is 1
- BG_COLOR, 24'h000000, RGB when font bit is 0 or outside the text area

Ports:
- hdmi_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- hdmi_pll_LOCKED  in  1  PLL lock; low acts exactly like rst
- char_addr  out  12  char RAM address = row*COLS + col (registered)
- char_data  in  8  char code; synchronous RAM, valid 1 cycle after char_addr
- font_addr  out  12  {char_code[7:0], glyph_line[3:0]} (registered)
- font_data  in  8  glyph row, MSB = leftmost pixel; valid 1 cycle after font_addr
- rgb  out  24  {R,G,B} pixel
- hs  out  1  horizontal sync, active high
- vs  out  1  vertical sync, active high
- de  out  1  data enable
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Reset/lock: while rst=1 or hdmi_pll_LOCKED=0:
  - h_cnt and v_cnt are forced to 0.
  - All pipeline valid bits are cleared.
  - Outputs are held at 0: rgb, hs, vs, de, frame_start, char_addr and font_addr.
  - Counting starts on the first edge where both conditions are false. A lock drop mid-frame flushes immediately, with no completion of the line or frame.
- Counters:
  - h_cnt runs 0..1055 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..627, and wraps to 0.
- Stage 0 (decode):
  - act = (h_cnt < 800) && (v_cnt < 600).
  - txt = act && (v_cnt < ROWS*16 = 592).
  - hs0 = 840 ≤ h_cnt < 968.
  - vs0 = 601 ≤ v_cnt < 605.
- Pipeline, measured in cycles after counter value (h,v):
  - +1: char_addr = (v>>4)*COLS + (h>>3) when txt, else 0. Use a 12-bit multiply-add; the maximum value is 3699. Carried forward: h[2:0], v[3:0], act, txt, hs0, vs0.
  - +2: char_data is sampled.
  - +3: font_addr = {char_data, v[3:0]} when txt, else 0.
  - +4: font_data is sampled.
  - +5: registered outputs are driven:
    - rgb = (txt && font_data[7-h[2:0]]) ? FG_COLOR : BG_COLOR when act, else 0.
    - de = act, hs = hs0, vs = vs0.
    - frame_start = (h==0 && v==0).
- Total latency is 5 cycles. hs, vs and de are delayed by the same amount as rgb, so they are always mutually aligned.
- Lines 592..599: de=1, rgb=BG_COLOR, no fetch is issued (addresses are 0).
- Blanking: rgb=0. Addresses are don't-care to the memories, but are driven 0.
- No back-pressure. The memories have fixed single-cycle read latency.

Test Plan:
1. rst=1 for 4 cycles, lock rises at cycle 10 → first de=1 and frame_start=1 exactly 5 cycles after the counters leave reset. hs period 1056 cycles, high 128; vs period 663168 cycles, high 4224; de high 800 of every 1056 cycles for 600 lines.
2. Char RAM model returns 0x41 everywhere, font model returns 0x81 for every line → each 8-pixel group on output is FG,BG,BG,BG,BG,BG,BG,FG across all text lines.
3. Counter at (h=15, v=33) → char_addr=201 at +1. Char RAM returns 0x5A → font_addr=0x5A1 at +3.
4. Output lines 592..599 with font model returning 0xFF → de=1, rgb=BG_COLOR for all 800 pixels, char_addr=0.
5. Drop hdmi_pll_LOCKED mid-line at (h=400, v=300) → next edge: hs=vs=de=0, rgb=0. Relock → timing restarts at (0,0), frame_start 5 cycles later.
6. Assert rst for 1 cycle mid-frame → same flush and restart as scenario 5. No stale pixel from the old frame appears after restart.
